if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h6800_0000: SimpleRISC nop encoding, driven on inst_IF whenever no valid instruction is held.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  1  hazard unit holds IF/OF; held instruction SHALL NOT be consumed.
REQ-006 branch_taken  in  1  redirect request from EX; highest priority.
REQ-007 branch_pc  in  32  redirect target, sampled when branch_taken=1.
REQ-008 imem_req_valid  out  1  instruction-memory request valid.
REQ-009 imem_req_addr  out  32  request byte address, equal to internal pc.
REQ-010 imem_req_ready  in  1  memory accepts request this cycle when valid&ready.
REQ-011 imem_rsp_valid  in  1  read data valid; one response per accepted request, in order, at least 1 cycle after acceptance.
REQ-012 imem_rsp_data  in  32  instruction word.
REQ-013 inst_IF  out  32  instruction to IF/OF pipe register.
REQ-014 pc_IF  out  32  address of inst_IF.
REQ-015 valid_IF  out  1  inst_IF/pc_IF hold a real instruction.

Function
REQ-016 The block SHALL have at most one outstanding memory request.
REQ-017 FSM states: S_REQ (drive request), S_WAIT (await response), S_HOLD (instruction held, downstream stalled), S_DRAIN (discard a squashed response).
REQ-018 S_REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go to S_WAIT, else stay.
REQ-019 S_WAIT: on imem_rsp_valid, load output buffer {inst=imem_rsp_data, pc=pc, valid=1}, set pc<=pc+4 (modulo 2^32, wrap 32'hFFFF_FFFC->0); next state S_HOLD if stall=1, else S_REQ.
REQ-020 A buffered instruction SHALL be consumed on a cycle with valid_IF=1 and stall=0; on consumption valid SHALL clear unless a new response loads the buffer the same cycle.
REQ-021 S_HOLD: outputs stable, imem_req_valid=0; go to S_REQ on the first cycle with stall=0.
REQ-022 Load-to-use latency: response data SHALL appear on inst_IF the cycle after imem_rsp_valid.
REQ-023 inst_IF SHALL equal NOP_INST and pc_IF SHALL hold its last value whenever valid_IF=0.
REQ-024 branch_taken=1 SHALL, in the next cycle: set pc<=branch_pc, clear valid_IF, force inst_IF=NOP_INST, irrespective of stall.
REQ-025 Branch in S_REQ without acceptance (req_ready=0) -> stay S_REQ with new address; branch in S_REQ with acceptance the same cycle -> S_DRAIN.
REQ-026 Branch in S_WAIT without rsp_valid -> S_DRAIN; with rsp_valid the same cycle -> response discarded, go to S_REQ.
REQ-027 Branch in S_HOLD or S_DRAIN -> pc updated; S_HOLD goes to S_REQ, S_DRAIN stays until response arrives.
REQ-028 S_DRAIN: imem_req_valid=0; on imem_rsp_valid drop data, go to S_REQ.
REQ-029 imem_req_addr SHALL NOT change while imem_req_valid=1 and imem_req_ready=0, except on branch redirect (REQ-025).

Reset
REQ-030 While rst_n=0: state=S_REQ, pc=RESET_PC, imem_req_valid=0, valid_IF=0, inst_IF=NOP_INST, pc_IF=32'h0.
REQ-031 First request SHALL be issued the first cycle after rst_n deasserts; reset mid-operation SHALL abandon any outstanding request, and responses arriving in the first cycle after reset are ignored only if the memory is reset together with this block.

Structure
REQ-032 Shared package simplerisc_pkg SHALL hold NOP_INST, INST_W=32, ADDR_W=32 and the fetch-state enumeration.
REQ-033 One sub-module is natural: if_out_buf, a 1-entry instruction/pc buffer with load, consume and flush inputs.

Verification
REQ-034 Reset, imem always ready, 1-cycle response -> requests at 0x0,0x4,0x8 back-to-back every 2 cycles; pc_IF follows 0x0,0x4,0x8.
REQ-035 stall=1 for 3 cycles while holding pc 0x4 -> inst_IF/pc_IF stable, imem_req_valid=0, fetch of 0x8 starts after release.
REQ-036 branch_taken with branch_pc=0x100 while a request to 0x8 is outstanding -> 0x8 data never appears; next request address 0x100; inst_IF=NOP for the gap.
REQ-037 branch_taken and stall together with valid instruction held -> valid_IF=0, NOP next cycle, fetch 0x100.
REQ-038 pc=32'hFFFF_FFFC fetched -> next request address 32'h0000_0000.
REQ-039 rst_n low during S_WAIT -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - shared SimpleRISC widths, nop encoding and fetch-state type
//
// Purpose : common definitions for the instruction-fetch slice.
// Contents: INST_W, ADDR_W, NOP_INST, fetch_state_t, pc_incr().
package simplerisc_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h6800_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // drive a request at pc
    S_WAIT  = 2'd1,  // request accepted, awaiting its response
    S_HOLD  = 2'd2,  // instruction held while downstream is stalled
    S_DRAIN = 2'd3   // swallow the response of a squashed request
  } fetch_state_t;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/response channel
//
// Purpose : groups the imem request and response handshake signals.
// Signals : req_valid/req_addr/req_ready  request channel
//           rsp_valid/rsp_data            response channel (no back-pressure)
// Modports: master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/if_out_buf.sv
// rtl/if_out_buf.sv - one-entry instruction/pc output buffer
//
// Purpose : holds the instruction presented to the IF/OF pipe register.
// Ports   : clk, rst_n               clock, async active-low reset
//           load, load_inst, load_pc write a new entry
//           consume                 entry taken downstream
//           flush                   branch squash (wins over load)
//           inst, pc, valid         buffered entry; inst is NOP_WORD when empty
module if_out_buf
  import simplerisc_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_WORD = NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [INST_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              consume,
  input  logic              flush,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;

  // pc_q is deliberately left untouched by flush/consume so pc_IF keeps
  // its last value while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      inst_q  <= load_inst;
      pc_q    <= load_pc;
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign inst  = valid_q ? inst_q : NOP_WORD;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - SimpleRISC instruction fetch unit, one outstanding request
//
// Purpose : fetches sequential instructions, redirects on branch, holds on stall.
// Ports   : clk, rst_n            clock, async active-low reset
//           stall                 downstream not taking inst_IF this cycle
//           branch_taken/pc       redirect from EX (highest priority)
//           imem                  instruction-memory channel (master side)
//           inst_IF/pc_IF/valid_IF instruction to the IF/OF pipe register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = simplerisc_pkg::NOP_INST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_pc,
  if_fetch_unit_if.master       imem,
  output logic [31:0]           inst_IF,
  output logic [31:0]           pc_IF,
  output logic                  valid_IF
);

  import simplerisc_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_valid;
  logic              buf_load;
  logic              buf_consume;
  logic              buf_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_valid = 1'b0;
    buf_load  = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // Do not fetch while an unconsumed instruction is stuck behind a
        // stall: its response would have nowhere to go.
        req_valid = !(buf_valid && stall);
        if (branch_taken) begin
          pc_d    = branch_pc;
          state_d = (req_valid && imem.req_ready) ? S_DRAIN : S_REQ;
        end else if (req_valid && imem.req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          pc_d    = branch_pc;
          state_d = imem.rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem.rsp_valid) begin
          buf_load = 1'b1;
          pc_d     = pc_incr(pc_q);
          state_d  = stall ? S_HOLD : S_REQ;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (branch_taken) begin
          pc_d = branch_pc;
        end
        if (imem.rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign buf_consume = buf_valid && !stall;

  // Request is masked during reset because the reset state is S_REQ.
  assign imem.req_valid = req_valid && rst_n;
  assign imem.req_addr  = pc_q;

  if_out_buf #(
    .NOP_WORD (NOP_INST)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_inst (imem.rsp_data),
    .load_pc   (pc_q),
    .consume   (buf_consume),
    .flush     (branch_taken),
    .inst      (inst_IF),
    .pc        (pc_IF),
    .valid     (buf_valid)
  );

  assign valid_IF = buf_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  import simplerisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] inst_IF;
  logic [31:0] pc_IF;
  logic        valid_IF;

  if_fetch_unit_if imem();

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .imem         (imem),
    .inst_IF      (inst_IF),
    .pc_IF        (pc_IF),
    .valid_IF     (valid_IF)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [31:0] bpc;
    logic        ready;
    logic        rsp;
    logic [31:0] rsp_addr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [21];

  int checks = 0;
  int errors = 0;

  // Memory model state for the random phase.
  logic [31:0] q_addr [$];
  int          q_dly  [$];
  logic [31:0] exp_pc;
  int          n_consumed;
  logic        prev_branch, prev_hold, prev_req_wait;
  logic [31:0] prev_pc, prev_inst, prev_addr;
  logic        cur_accept, cur_consume;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bp,
                              input logic rd, input logic rv, input logic [31:0] ra,
                              input logic erv, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s;   v.br = b;     v.bpc = bp;  v.ready = rd;
    v.rsp = rv;    v.rsp_addr = ra;
    v.e_rv = erv;  v.e_addr = ea; v.e_v = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bp,
                       input logic rd, input logic rv, input logic [31:0] ra);
    stall          = s;
    branch_taken   = b;
    branch_pc      = bp;
    imem.req_ready = rd;
    imem.rsp_valid = rv;
    imem.rsp_data  = rv ? mem_word(ra) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic erv, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ep);
    chk({tag, "_req_valid"}, 32'(imem.req_valid), 32'(erv));
    chk({tag, "_req_addr"},  imem.req_addr, ea);
    chk({tag, "_valid_IF"},  32'(valid_IF), 32'(ev));
    chk({tag, "_pc_IF"},     pc_IF, ep);
    chk({tag, "_inst_IF"},   inst_IF, ev ? mem_word(ep) : NOP_INST);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    //          stall br bpc          rdy rsp raddr       | rv addr         v  pc
    tbl[0]  = mk(0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h0,       0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,       0, 1, 32'h0,        0, 32'h0,       0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h4,       1, 32'h0);
    tbl[3]  = mk(1, 0, 32'h0,       0, 1, 32'h4,        0, 32'h4,       0, 32'h0);
    tbl[4]  = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'h8,       1, 32'h4);
    tbl[5]  = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'h8,       1, 32'h4);
    tbl[6]  = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'h8,       1, 32'h4);
    tbl[7]  = mk(0, 0, 32'h0,       1, 0, 32'h0,        0, 32'h8,       1, 32'h4);
    tbl[8]  = mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h8,       0, 32'h4);
    tbl[9]  = mk(0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h8,       0, 32'h4);
    tbl[10] = mk(0, 1, 32'h100,     0, 0, 32'h0,        0, 32'h8,       0, 32'h4);
    tbl[11] = mk(0, 0, 32'h0,       0, 1, 32'h8,        0, 32'h100,     0, 32'h4);
    tbl[12] = mk(0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h100,     0, 32'h4);
    tbl[13] = mk(1, 0, 32'h0,       0, 1, 32'h100,      0, 32'h100,     0, 32'h4);
    tbl[14] = mk(1, 0, 32'h0,       1, 0, 32'h0,        0, 32'h104,     1, 32'h100);
    tbl[15] = mk(1, 1, 32'h100,     1, 0, 32'h0,        0, 32'h104,     1, 32'h100);
    tbl[16] = mk(1, 0, 32'h0,       0, 0, 32'h0,        1, 32'h100,     0, 32'h100);
    tbl[17] = mk(0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h100,     0, 32'h100);
    tbl[18] = mk(0, 0, 32'h0,       0, 1, 32'h100,      0, 32'h100,     0, 32'h100);
    tbl[19] = mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h104,     1, 32'h100);
    tbl[20] = mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h104,     0, 32'h100);

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    repeat (2) tick();
    chk("rst_req_valid", 32'(imem.req_valid), 32'h0);
    chk("rst_req_addr",  imem.req_addr, 32'h0);
    chk("rst_valid_IF",  32'(valid_IF), 32'h0);
    chk("rst_inst_IF",   inst_IF, NOP_INST);
    chk("rst_pc_IF",     pc_IF, 32'h0);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].bpc, tbl[i].ready, tbl[i].rsp, tbl[i].rsp_addr);
      chk_outs($sformatf("v%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_pc);
      tick();
    end

    // Address wrap at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk("wrap_req_addr", imem.req_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_outs("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
    tick();

    // Asynchronous reset while a request is outstanding.
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc_IF",     pc_IF, 32'h0);
    chk("arst_req_valid", 32'(imem.req_valid), 32'h0);
    chk("arst_inst_IF",   inst_IF, NOP_INST);
    tick();
    chk("arst_hold_req_valid", 32'(imem.req_valid), 32'h0);
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk("arst_restart_req_valid", 32'(imem.req_valid), 32'h1);
    chk("arst_restart_addr",      imem.req_addr, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 1, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk_outs("arst_first", 1'b1, 32'h4, 1'b1, 32'h0);
    tick();

    // Randomized run against a transaction-level reference.
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    rst_n = 1'b1;
    exp_pc        = 32'h0;
    n_consumed    = 0;
    prev_branch   = 1'b0;
    prev_hold     = 1'b0;
    prev_req_wait = 1'b0;
    prev_pc       = 32'h0;
    prev_inst     = 32'h0;
    prev_addr     = 32'h0;

    for (int c = 0; c < 3000; c++) begin
      logic        s, b, rd, rv;
      logic [31:0] bp;
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 19) == 0);
      bp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      rd = ($urandom_range(0, 2) != 0);
      rv = (q_addr.size() > 0) && (q_dly[0] == 0);
      drive(s, b, bp, rd, rv, rv ? q_addr[0] : 32'h0);

      if (!valid_IF) chk("rnd_nop_when_empty", inst_IF, NOP_INST);
      if (prev_branch) chk("rnd_squash_valid", 32'(valid_IF), 32'h0);
      if (prev_hold) begin
        chk("rnd_hold_valid", 32'(valid_IF), 32'h1);
        chk("rnd_hold_pc",    pc_IF, prev_pc);
        chk("rnd_hold_inst",  inst_IF, prev_inst);
      end
      if (prev_req_wait && imem.req_valid) chk("rnd_addr_stable", imem.req_addr, prev_addr);

      cur_consume = valid_IF && !s && !b;
      if (cur_consume) begin
        chk("rnd_consume_pc",   pc_IF, exp_pc);
        chk("rnd_consume_inst", inst_IF, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (b) exp_pc = bp;

      cur_accept = imem.req_valid && rd;
      if (cur_accept) chk("rnd_one_outstanding", 32'(q_addr.size()), 32'h0);

      prev_branch   = b;
      prev_hold     = valid_IF && s && !b;
      prev_pc       = pc_IF;
      prev_inst     = inst_IF;
      prev_req_wait = imem.req_valid && !rd && !b;
      prev_addr     = imem.req_addr;

      @(posedge clk);
      if (rv) begin
        void'(q_addr.pop_front());
        void'(q_dly.pop_front());
      end
      foreach (q_dly[k]) if (q_dly[k] > 0) q_dly[k]--;
      if (cur_accept) begin
        q_addr.push_back(imem.req_addr);
        q_dly.push_back(int'($urandom_range(0, 2)));
      end
      @(negedge clk);
    end

    chk("rnd_progress", 32'(n_consumed >= 200), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
